nios2_debug_mon_sequencer: RTL and testbench

NIOS2_DEBUG_MON_SEQUENCER -- requirements
Module: nios2_debug_mon_sequencer

---
 rtl/nios2_debug_mon_sequencer_pkg.sv | 20 ++
 rtl/nios2_debug_mon_arb.sv | 37 +++
 rtl/nios2_debug_mon_sequencer.sv | 169 ++++++++++++++++
 tb/tb_nios2_debug_mon_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_debug_mon_sequencer_pkg.sv
// rtl/nios2_debug_mon_sequencer_pkg.sv - shared types and constants for the debug monitor sequencer
package nios2_debug_mon_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_J_ACC,
        ST_A_ACC,
        ST_RD_WAIT,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD,
        OP_READ,
        OP_WRITE
    } op_t;

    localparam logic [31:0] RANGE_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/nios2_debug_mon_arb.sv
// rtl/nios2_debug_mon_arb.sv - JTAG/Avalon grant with alternating priority on contested requests
module nios2_debug_mon_arb (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic j_req,
    input  logic a_req,
    output logic grant_j,
    output logic grant_a
);

    logic prefer_j;

    always_comb begin
        grant_j = 1'b0;
        grant_a = 1'b0;
        if (en) begin
            if (j_req && a_req) begin
                grant_j = prefer_j;
                grant_a = !prefer_j;
            end else begin
                grant_j = j_req;
                grant_a = a_req;
            end
        end
    end

    // Priority only moves when both sides actually competed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prefer_j <= 1'b1;
        end else if (en && j_req && a_req) begin
            prefer_j <= !prefer_j;
        end
    end

endmodule

// File: rtl/nios2_debug_mon_sequencer.sv
// rtl/nios2_debug_mon_sequencer.sv - debug RAM access sequencer for JTAG and Avalon; DBG_MON_RANGE_CHECK_EN adds address range checking
module nios2_debug_mon_sequencer
    import nios2_debug_mon_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int RAM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

`ifdef DBG_MON_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    state_t            state, state_nxt;
    logic              jp_valid, jp_rd;
    op_t               jp_op, cur_op;
    logic [ADDR_W-1:0] jp_addr, jtag_addr, acc_addr;
    logic [31:0]       jp_data;
    logic              cur_j;
    logic              grant_j, grant_a;
    logic              any_pulse, j_active, accept, drop, a_req, out_of_range;
    logic              unused_jdo;

    assign unused_jdo   = ^{jdo[37:35], jdo[1:0]};
    assign any_pulse    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign j_active     = cur_j && (state != ST_IDLE);
    assign accept       = any_pulse && !jp_valid && !j_active;
    assign drop         = any_pulse && !accept;
    assign a_req        = avs_read | avs_write;
    assign acc_addr     = (state == ST_J_ACC) ? jtag_addr : avs_address;
    assign out_of_range = RANGE_CHK && (int'(acc_addr) >= RAM_DEPTH);

    assign avs_waitrequest = reset_n && a_req && !((state == ST_DONE) && !cur_j);

    nios2_debug_mon_arb u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state == ST_IDLE),
        .j_req   (jp_valid),
        .a_req   (a_req),
        .grant_j (grant_j),
        .grant_a (grant_a)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_addr  = '0;
        ram_wr    = 1'b0;
        ram_wdata = '0;
        case (state)
            ST_IDLE: begin
                if (grant_j) begin
                    state_nxt = (jp_op == OP_LOAD && !jp_rd) ? ST_DONE : ST_J_ACC;
                end else if (grant_a) begin
                    state_nxt = ST_A_ACC;
                end
            end
            ST_J_ACC, ST_A_ACC: begin
                if (out_of_range) begin
                    state_nxt = ST_DONE;
                end else begin
                    ram_addr = acc_addr;
                    if (cur_op == OP_WRITE) begin
                        ram_wr    = 1'b1;
                        ram_wdata = cur_j ? jp_data : avs_writedata;
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jp_valid      <= 1'b0;
            jp_rd         <= 1'b0;
            jp_op         <= OP_LOAD;
            jp_addr       <= '0;
            jp_data       <= '0;
            cur_j         <= 1'b0;
            cur_op        <= OP_LOAD;
            jtag_addr     <= '0;
            MonDReg       <= '0;
            avs_readdata  <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            if (accept) begin
                jp_valid      <= 1'b1;
                jp_rd         <= jdo[34];
                jp_addr       <= jdo[ADDR_W+1:2];
                jp_data       <= jdo[34:3];
                jp_op         <= take_action_ocimem_a ? OP_LOAD :
                                 take_action_ocimem_b ? OP_WRITE : OP_READ;
                monitor_ready <= 1'b0;
                monitor_error <= 1'b0;
            end
            if (drop) begin
                monitor_error <= 1'b1;
            end
            if (grant_j) begin
                jp_valid <= 1'b0;
                cur_j    <= 1'b1;
                cur_op   <= (jp_op == OP_LOAD) ? OP_READ : jp_op;
                if (jp_op == OP_LOAD) begin
                    jtag_addr <= jp_addr;
                end
            end else if (grant_a) begin
                cur_j  <= 1'b0;
                cur_op <= avs_write ? OP_WRITE : OP_READ;
            end
            // The JTAG pointer advances even when the access was rejected for range.
            if (state == ST_J_ACC) begin
                jtag_addr <= jtag_addr + ADDR_W'(1);
                if (out_of_range) begin
                    monitor_error <= 1'b1;
                end
            end
            if (state == ST_A_ACC && out_of_range && cur_op == OP_READ) begin
                avs_readdata <= RANGE_ERR_DATA;
            end
            if (state == ST_RD_WAIT) begin
                if (cur_j) begin
                    MonDReg <= ram_rdata;
                end else begin
                    avs_readdata <= ram_rdata;
                end
            end
            if (state_nxt == ST_DONE && (grant_j || cur_j)) begin
                monitor_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nios2_debug_mon_sequencer.sv
// tb/tb_nios2_debug_mon_sequencer.sv - self-checking bench: vector table, directed corner cases, random ops against a reference model
module tb_nios2_debug_mon_sequencer;

    localparam int ADDR_W = 8;
`ifdef DBG_MON_RANGE_CHECK_EN
    localparam int DEPTH = 128;
`else
    localparam int DEPTH = 256;
`endif
    localparam int K_AW = 0, K_AR = 1, K_ARW = 2, K_JL = 3, K_JLR = 4, K_JW = 5, K_JR = 6;

    typedef struct {
        int          kind;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        take_action_ocimem_a = 1'b0, take_action_ocimem_b = 1'b0, take_no_action_ocimem_a = 1'b0;
    logic [7:0]  avs_address = '0;
    logic        avs_read = 1'b0, avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    always #5 clk = ~clk;

    nios2_debug_mon_sequencer #(.ADDR_W(ADDR_W), .RAM_DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wr                  (ram_wr),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // Synchronous debug RAM with one cycle of read latency.
    logic [31:0] mem [256];
    int          wr_count = 0;
    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] <= ram_wdata;
            wr_count      <= wr_count + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    logic [31:0] ref_mem [256];
    int          ref_jaddr = 0;
    logic [31:0] ref_mdr = '0;
    int          total = 0, bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model(input int kind, input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] er, output int el, output logic ee);
        er = ref_mdr;
        el = 0;
        ee = 1'b0;
        case (kind)
            K_AW, K_ARW: begin
                if (int'(a) < DEPTH) ref_mem[a] = d;
                el = 2;
            end
            K_AR: begin
                er = (int'(a) < DEPTH) ? ref_mem[a] : 32'hDEAD_BEEF;
                el = (int'(a) < DEPTH) ? 3 : 2;
            end
            K_JL: ref_jaddr = int'(a);
            default: begin
                if (kind == K_JLR) ref_jaddr = int'(a);
                if (ref_jaddr >= DEPTH) ee = 1'b1;
                else if (kind == K_JW) ref_mem[ref_jaddr] = d;
                else ref_mdr = ref_mem[ref_jaddr];
                ref_jaddr = (ref_jaddr + 1) % 256;
                er = ref_mdr;
            end
        endcase
    endtask

    task automatic run_op(input int kind, input logic [7:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int lat, output logic err, output logic rdy);
        lat = 0;
        err = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
        if (kind <= K_ARW) begin
            avs_address   = a;
            avs_writedata = d;
            avs_read      = (kind == K_AR || kind == K_ARW);
            avs_write     = (kind == K_AW || kind == K_ARW);
            do begin
                @(negedge clk);
                lat++;
            end while (avs_waitrequest && lat < 20);
            if (avs_waitrequest) lat = -1;
            rd        = avs_readdata;
            avs_read  = 1'b0;
            avs_write = 1'b0;
        end else begin
            jdo = '0;
            if (kind == K_JW) begin
                jdo[34:3] = d;
                take_action_ocimem_b = 1'b1;
            end else if (kind == K_JR) begin
                take_no_action_ocimem_a = 1'b1;
            end else begin
                jdo[ADDR_W+1:2] = a;
                jdo[34] = (kind == K_JLR);
                take_action_ocimem_a = 1'b1;
            end
            @(negedge clk);
            take_action_ocimem_a = 1'b0;
            take_action_ocimem_b = 1'b0;
            take_no_action_ocimem_a = 1'b0;
            while (!monitor_ready && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            rdy = monitor_ready;
            err = monitor_error;
            rd  = MonDReg;
        end
        @(negedge clk);
    endtask

    vec_t        tab [16];
    logic [31:0] rd, er, rdv;
    int          lat, el, wc, kind, j_at, a_at;
    logic        err, ee, rdy;
    logic [7:0]  a;
    logic [31:0] d;

    initial begin
        tab[0]  = '{K_AW,  8'h10, 32'hA5A5_A5A5, 32'h0,         2};
        tab[1]  = '{K_AR,  8'h10, 32'h0,         32'hA5A5_A5A5, 3};
        tab[2]  = '{K_AW,  8'h11, 32'h1234_5678, 32'h0,         2};
        tab[3]  = '{K_JLR, 8'h10, 32'h0,         32'hA5A5_A5A5, 0};
        tab[4]  = '{K_JR,  8'h00, 32'h0,         32'h1234_5678, 0};
        tab[5]  = '{K_JL,  8'hFE, 32'h0,         32'h1234_5678, 0};
        tab[6]  = '{K_JW,  8'h00, 32'h1,         32'h1234_5678, 0};
        tab[7]  = '{K_JW,  8'h00, 32'h2,         32'h1234_5678, 0};
        tab[8]  = '{K_JW,  8'h00, 32'h3,         32'h1234_5678, 0};
        tab[9]  = '{K_AR,  8'hFE, 32'h0,         32'h1,         3};
        tab[10] = '{K_AR,  8'hFF, 32'h0,         32'h2,         3};
        tab[11] = '{K_AR,  8'h00, 32'h0,         32'h3,         3};
        tab[12] = '{K_ARW, 8'h20, 32'hCAFE_F00D, 32'h0,         2};
        tab[13] = '{K_AR,  8'h20, 32'h0,         32'hCAFE_F00D, 3};
        tab[14] = '{K_JLR, 8'hFF, 32'h0,         32'h2,         0};
        tab[15] = '{K_JR,  8'h00, 32'h0,         32'h3,         0};

        repeat (2) @(negedge clk);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_ram_wr", 32'(ram_wr), 32'h0);
        chk("rst_ready", 32'(monitor_ready), 32'h0);
        chk("rst_error", 32'(monitor_error), 32'h0);
        chk("rst_waitreq", 32'(avs_waitrequest), 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            d = $urandom;
            model(K_AW, 8'(i), d, er, el, ee);
            run_op(K_AW, 8'(i), d, rd, lat, err, rdy);
        end

`ifndef DBG_MON_RANGE_CHECK_EN
        for (int i = 0; i < 16; i++) begin
            model(tab[i].kind, tab[i].addr, tab[i].data, er, el, ee);
            run_op(tab[i].kind, tab[i].addr, tab[i].data, rd, lat, err, rdy);
            if (tab[i].kind <= K_ARW) begin
                chk($sformatf("tab%0d_lat", i), 32'(lat), 32'(tab[i].lat));
                if (tab[i].kind == K_AR) chk($sformatf("tab%0d_rd", i), rd, tab[i].exp);
            end else begin
                chk($sformatf("tab%0d_ready", i), 32'(rdy), 32'd1);
                chk($sformatf("tab%0d_mondreg", i), rd, tab[i].exp);
                chk($sformatf("tab%0d_error", i), 32'(err), 32'd0);
            end
        end
`else
        wc = wr_count;
        run_op(K_AR, 8'h80, 32'h0, rd, lat, err, rdy);
        chk("range_rd", rd, 32'hDEAD_BEEF);
        chk("range_no_wr", 32'(wr_count), 32'(wc));
`endif

        for (int n = 0; n < 150; n++) begin
            kind = int'($urandom_range(0, 6));
            a    = 8'($urandom);
            d    = $urandom;
            model(kind, a, d, er, el, ee);
            run_op(kind, a, d, rd, lat, err, rdy);
            if (kind <= K_ARW) begin
                chk("rnd_lat", 32'(lat), 32'(el));
                if (kind == K_AR) chk("rnd_rd", rd, er);
            end else begin
                chk("rnd_ready", 32'(rdy), 32'd1);
                chk("rnd_mondreg", rd, er);
                chk("rnd_error", 32'(err), 32'(ee));
            end
        end
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem%0d", i), mem[i], ref_mem[i]);

        // Reset in the write cycle of an Avalon access must suppress the write.
        @(negedge clk);
        avs_address   = 8'h40;
        avs_writedata = ~ref_mem[8'h40];
        avs_write     = 1'b1;
        @(negedge clk);
        chk("pre_rst_ram_wr", 32'(ram_wr), 32'd1);
        wc = wr_count;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("mid_rst_waitreq", 32'(avs_waitrequest), 32'd0);
        chk("mid_rst_mondreg", MonDReg, 32'h0);
        chk("mid_rst_ready", 32'(monitor_ready), 32'd0);
        chk("mid_rst_readdata", avs_readdata, 32'h0);
        chk("mid_rst_ram_addr", 32'(ram_addr), 32'h0);
        @(negedge clk);
        avs_write = 1'b0;
        chk("mid_rst_wr_count", 32'(wr_count), 32'(wc));
        chk("mid_rst_mem", mem[8'h40], ref_mem[8'h40]);
        reset_n   = 1'b1;
        ref_jaddr = 0;
        ref_mdr   = '0;
        @(negedge clk);

        // Two contested rounds: first JTAG wins, then Avalon.
        for (int r = 0; r < 2; r++) begin
            take_no_action_ocimem_a = 1'b1;
            @(negedge clk);
            take_no_action_ocimem_a = 1'b0;
            avs_address = (r == 0) ? 8'h55 : 8'h66;
            avs_read    = 1'b1;
            j_at = -1;
            a_at = -1;
            rdv  = '0;
            for (int c = 1; c <= 20 && (j_at < 0 || a_at < 0); c++) begin
                @(negedge clk);
                if (j_at < 0 && monitor_ready) j_at = c;
                if (a_at < 0 && !avs_waitrequest) begin
                    a_at = c;
                    rdv = avs_readdata;
                    avs_read = 1'b0;
                end
            end
            avs_read = 1'b0;
            chk($sformatf("arb%0d_both_done", r), 32'(j_at >= 0 && a_at >= 0), 32'd1);
            chk($sformatf("arb%0d_jtag_first", r), 32'(j_at < a_at), (r == 0) ? 32'd1 : 32'd0);
            model(K_JR, 8'h0, 32'h0, er, el, ee);
            chk($sformatf("arb%0d_mondreg", r), MonDReg, er);
            chk($sformatf("arb%0d_rd", r), rdv, ref_mem[avs_address]);
            @(negedge clk);
        end

        // Second read pulse while the first is in RD_WAIT is dropped.
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        repeat (2) @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        model(K_JR, 8'h0, 32'h0, er, el, ee);
        chk("drop_error", 32'(monitor_error), 32'd1);
        chk("drop_ready", 32'(monitor_ready), 32'd1);
        chk("drop_mondreg", MonDReg, er);
        repeat (4) @(negedge clk);
        chk("drop_no_new_op", 32'(monitor_ready), 32'd1);
        chk("drop_error_held", 32'(monitor_error), 32'd1);
        model(K_JR, 8'h0, 32'h0, er, el, ee);
        run_op(K_JR, 8'h0, 32'h0, rd, lat, err, rdy);
        chk("after_drop_mondreg", rd, er);
        chk("after_drop_error_clr", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
